// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified I/D memory port arbiter.
// Optional build macro ARB_RR_EN selects round-robin tie-breaking.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } arb_state_e;

   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

   localparam int unsigned BYTE_W = 8;

   function automatic int unsigned byte_lanes(input int unsigned data_w);
      return data_w / BYTE_W;
   endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational choice between the fetch and load/store ports.
// ARB_RR_EN: ties go to the port not granted last; otherwise D always wins ties.
module arb_pick
   import mem_arb_pkg::*;
(
   input  logic i_elig_i,
   input  logic d_elig_i,
`ifdef ARB_RR_EN
   input  logic last_grant_i,
`endif
   output logic grant_i_o,
   output logic grant_d_o
);

   always_comb begin
      grant_i_o = 1'b0;
      grant_d_o = 1'b0;
      if (i_elig_i && d_elig_i) begin
`ifdef ARB_RR_EN
         if (last_grant_i == PORT_D) begin
            grant_i_o = 1'b1;
         end else begin
            grant_d_o = 1'b1;
         end
`else
         // D is the older instruction in the pipeline
         grant_d_o = 1'b1;
`endif
      end else begin
         grant_i_o = i_elig_i;
         grant_d_o = d_elig_i;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port, 1-cycle-latency RAM between MIPS fetch (I) and load/store (D).
// Build macro ARB_RR_EN enables round-robin tie-breaking with a last_grant register.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter  int unsigned ADDR_W = 10,
   parameter  int unsigned DATA_W = 32,
   localparam int unsigned BE_W   = byte_lanes(DATA_W)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [31:0]       i_addr,
   output logic              i_ack,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [BE_W-1:0]   d_be,
   input  logic [31:0]       d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              ram_en,
   output logic [BE_W-1:0]   ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   arb_state_e state_q, state_d;
   logic       i_elig, d_elig;
   logic       grant_i, grant_d;
   logic       unused_addr_bits;

   // Byte offset and bits above the RAM depth are dropped (accesses wrap)
   assign unused_addr_bits = ^{i_addr[31:ADDR_W+2], i_addr[1:0],
                               d_addr[31:ADDR_W+2], d_addr[1:0]};

   // The port currently being acked sits out this cycle's arbitration
   always_comb begin
      i_elig = rst && i_req && (state_q != BUSY_I);
      d_elig = rst && d_req && (state_q != BUSY_D);
   end

`ifdef ARB_RR_EN
   logic last_grant_q, last_grant_d;

   always_comb begin
      last_grant_d = last_grant_q;
      if (grant_d) begin
         last_grant_d = PORT_D;
      end else if (grant_i) begin
         last_grant_d = PORT_I;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_grant_q <= PORT_D;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end
`endif

   arb_pick u_arb_pick (
      .i_elig_i     (i_elig),
      .d_elig_i     (d_elig),
`ifdef ARB_RR_EN
      .last_grant_i (last_grant_q),
`endif
      .grant_i_o    (grant_i),
      .grant_d_o    (grant_d)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, RAM drive for the grant cycle, ack/rdata for the previous grant
   always_comb begin
      state_d   = IDLE;
      ram_en    = 1'b0;
      ram_we    = '0;
      ram_addr  = i_addr[ADDR_W+1:2];
      ram_wdata = d_wdata;
      i_ack     = 1'b0;
      d_ack     = 1'b0;
      i_rdata   = '0;
      d_rdata   = '0;

      case (state_q)
         BUSY_I: begin
            i_ack   = 1'b1;
            i_rdata = ram_rdata;
         end
         BUSY_D: begin
            d_ack   = 1'b1;
            d_rdata = ram_rdata;
         end
         default: ;
      endcase

      if (grant_d) begin
         state_d  = BUSY_D;
         ram_en   = 1'b1;
         ram_addr = d_addr[ADDR_W+1:2];
         ram_we   = d_we ? d_be : '0;
      end else if (grant_i) begin
         state_d  = BUSY_I;
         ram_en   = 1'b1;
      end
   end

endmodule
